// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if -- control/data bundle for the lfsr_gen sequence generator.
//
//   ena   advance the state by STEPS single steps this cycle
//   dir   0 = forward, 1 = backward (only meaningful with ena)
//   load  replace the state with seed this cycle
//   seed  value written by load (any value, including 0)
//   out   current registered state
//   wrap  registered one-cycle pulse: the last advance passed through state 0
//
// master: the agent driving the generator; slave: the generator itself.
interface lfsr_gen_if #(
   parameter int unsigned WIDTH = 20
);
   logic             ena;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] out;
   logic             wrap;

   modport master (
      output ena, dir, load, seed,
      input  out, wrap
   );

   modport slave (
      input  ena, dir, load, seed,
      output out, wrap
   );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen -- full-period (2^WIDTH, including all-zero) pseudo-random
// sequence generator with programmable taps, STEPS steps per clock,
// reversible stepping, seed load and a wrap pulse.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous, active-high: out <= 0, wrap <= 0
//   bus   lfsr_gen_if.slave: ena, dir, load, seed in; out, wrap out
//
// Per-edge priority: rst > load > ena > hold.
module lfsr_gen #(
   parameter int unsigned          WIDTH = 20,
   parameter logic [WIDTH-1:0]     TAPS  = 20'h90000,
   parameter int unsigned          STEPS = 1
) (
   input  logic      clk,
   input  logic      rst,
   lfsr_gen_if.slave bus
);

   // Elaboration-time legality checks.
   if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH=%0d outside 3..32", WIDTH);
   end
   if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
      $error("lfsr_gen: STEPS=%0d outside 1..WIDTH", STEPS);
   end
   if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
      $error("lfsr_gen: TAPS[WIDTH-1] must be set");
   end

   // Forward single step. The zero-detect term splices state 0 between
   // 100..0 and 0..01 so the period covers all 2^WIDTH states.
   function automatic logic [WIDTH-1:0] step_fwd(input logic [WIDTH-1:0] s);
      logic f;
      f = (^(s & TAPS)) ^ (s[WIDTH-2:0] == '0);
      return {s[WIDTH-2:0], f};
   endfunction

   // Backward single step: recovers the bit shifted out by the forward
   // step, since n[0] = s[W-1] ^ ^(s[W-2:0] & TAPS[W-2:0]) ^ zero(s[W-2:0]).
   function automatic logic [WIDTH-1:0] step_bwd(input logic [WIDTH-1:0] n);
      logic b;
      b = n[0] ^ (^(n[WIDTH-1:1] & TAPS[WIDTH-2:0])) ^ (n[WIDTH-1:1] == '0);
      return {b, n[WIDTH-1:1]};
   endfunction

   logic [WIDTH-1:0] state_q;
   logic             wrap_q;
   logic [WIDTH-1:0] state_adv;
   logic             zero_hit;

   // STEPS chained single steps in the selected direction; zero_hit
   // records whether any intermediate state s1..sSTEPS is all-zero.
   always_comb begin
      logic [WIDTH-1:0] s;
      s        = state_q;
      zero_hit = 1'b0;
      for (int unsigned i = 0; i < STEPS; i++) begin
         s        = bus.dir ? step_bwd(s) : step_fwd(s);
         zero_hit = zero_hit | (s == '0);
      end
      state_adv = s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
         wrap_q  <= 1'b0;
      end else if (bus.load) begin
         state_q <= bus.seed;
         wrap_q  <= 1'b0;
      end else if (bus.ena) begin
         state_q <= state_adv;
         wrap_q  <= zero_hit;
      end else begin
         wrap_q  <= 1'b0;
      end
   end

   assign bus.out  = state_q;
   assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen -- directed, table-driven bench for lfsr_gen.
//   u_dut1 : WIDTH=4, TAPS=4'h9, STEPS=1 (vector table)
//   u_dut3 : WIDTH=4, TAPS=4'h9, STEPS=3 (hand sequence)
//   u_dut20: default parameters (hand sequence)
module tb_lfsr_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1, rst3, rst20;

   lfsr_gen_if #(.WIDTH(4))  if1 ();
   lfsr_gen_if #(.WIDTH(4))  if3 ();
   lfsr_gen_if #(.WIDTH(20)) if20 ();

   lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .STEPS(1)) u_dut1 (
      .clk(clk), .rst(rst1), .bus(if1)
   );
   lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .STEPS(3)) u_dut3 (
      .clk(clk), .rst(rst3), .bus(if3)
   );
   lfsr_gen #(.WIDTH(20), .TAPS(20'h90000), .STEPS(1)) u_dut20 (
      .clk(clk), .rst(rst20), .bus(if20)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       rst;
      logic       load;
      logic       ena;
      logic       dir;
      logic [3:0] seed;
      logic [3:0] exp_out;
      logic       exp_wrap;
   } vec_t;

   vec_t vecs[$];

   // Hand-computed forward orbit of WIDTH=4, TAPS=4'h9 starting at 0.
   logic [3:0] seq [16] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA,
                            4'h5, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

   task automatic add(input logic r, input logic l, input logic e, input logic d,
                      input logic [3:0] sd, input logic [3:0] eo, input logic ew);
      vec_t v;
      v.rst = r; v.load = l; v.ena = e; v.dir = d;
      v.seed = sd; v.exp_out = eo; v.exp_wrap = ew;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] got_out, input logic got_wrap,
                        input logic [31:0] exp_out, input logic exp_wrap);
      checks++;
      if (got_out !== exp_out || got_wrap !== exp_wrap) begin
         failures++;
         $display("FAIL %s: out=%h wrap=%b, expected out=%h wrap=%b",
                  name, got_out, got_wrap, exp_out, exp_wrap);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst1 = 1'b1; rst3 = 1'b1; rst20 = 1'b1;
      if1.ena = 0;  if1.dir = 0;  if1.load = 0;  if1.seed = '0;
      if3.ena = 0;  if3.dir = 0;  if3.load = 0;  if3.seed = '0;
      if20.ena = 0; if20.dir = 0; if20.load = 0; if20.seed = '0;

      // ---- vector table for u_dut1 ----
      add(1, 0, 0, 0, 4'h0, 4'h0, 0);                 // reset state
      for (int i = 1; i <= 16; i++)                   // full forward orbit
         add(0, 0, 1, 0, 4'h0, seq[i % 16], (i == 16));
      add(0, 1, 0, 0, 4'hE, 4'hE, 0);                 // load E
      add(0, 0, 1, 1, 4'h0, 4'hF, 0);                 // backward F,7,3,1,0
      add(0, 0, 1, 1, 4'h0, 4'h7, 0);
      add(0, 0, 1, 1, 4'h0, 4'h3, 0);
      add(0, 0, 1, 1, 4'h0, 4'h1, 0);
      add(0, 0, 1, 1, 4'h0, 4'h0, 1);
      add(0, 0, 1, 1, 4'h0, 4'h8, 0);                 // backward out of 0
      add(0, 1, 1, 0, 4'h5, 4'h5, 0);                 // load beats ena
      add(1, 1, 1, 0, 4'h5, 4'h0, 0);                 // rst beats load/ena
      add(0, 1, 0, 0, 4'hA, 4'hA, 0);                 // load A, then idle
      for (int i = 0; i < 10; i++)
         add(0, 0, 0, 0, 4'h3, 4'hA, 0);
      add(0, 0, 1, 0, 4'h0, 4'h5, 0);                 // fwd 3 ...
      add(0, 0, 1, 0, 4'h0, 4'hB, 0);
      add(0, 0, 1, 0, 4'h0, 4'h6, 0);
      add(0, 0, 1, 1, 4'h0, 4'hB, 0);                 // ... back 3, no bubble
      add(0, 0, 1, 1, 4'h0, 4'h5, 0);
      add(0, 0, 1, 1, 4'h0, 4'hA, 0);
      add(0, 1, 0, 0, 4'h0, 4'h0, 0);                 // load 0: not stalled
      add(0, 0, 1, 0, 4'h0, 4'h1, 0);
      add(0, 1, 0, 0, 4'h8, 4'h8, 0);                 // wrap then load clears it
      add(0, 0, 1, 0, 4'h0, 4'h0, 1);
      add(0, 1, 0, 0, 4'h3, 4'h3, 0);
      add(0, 0, 1, 0, 4'h0, 4'h7, 0);
      add(0, 0, 0, 0, 4'h0, 4'h7, 0);
      add(0, 1, 0, 0, 4'h8, 4'h8, 0);                 // wrap then idle clears it
      add(0, 0, 1, 0, 4'h0, 4'h0, 1);
      add(0, 0, 0, 0, 4'h0, 4'h0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst1     = vecs[i].rst;
         if1.load = vecs[i].load;
         if1.ena  = vecs[i].ena;
         if1.dir  = vecs[i].dir;
         if1.seed = vecs[i].seed;
         tick();
         check($sformatf("vec[%0d]", i), {28'd0, if1.out}, if1.wrap,
               {28'd0, vecs[i].exp_out}, vecs[i].exp_wrap);
      end
      rst1 = 1'b0; if1.ena = 0; if1.load = 0;

      // ---- STEPS=3: forward 16 cycles, then backward 6 ----
      rst3 = 1'b1;
      tick();
      check("s3_reset", {28'd0, if3.out}, if3.wrap, 32'd0, 1'b0);
      rst3 = 1'b0;
      if3.ena = 1'b1;
      if3.dir = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         int   idx;
         logic ew;
         idx = (3 * c) % 16;
         ew  = 1'b0;
         for (int k = 0; k < 3; k++)
            if (((3 * c - k) % 16) == 0) ew = 1'b1;
         tick();
         check($sformatf("s3_fwd[%0d]", c), {28'd0, if3.out}, if3.wrap,
               {28'd0, seq[idx]}, ew);
      end
      if3.dir = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         int   idx;
         logic ew;
         idx = (48 - 3 * c) % 16;
         ew  = 1'b0;
         for (int k = 0; k < 3; k++)
            if (((48 - 3 * c + k) % 16) == 0) ew = 1'b1;
         tick();
         check($sformatf("s3_bwd[%0d]", c), {28'd0, if3.out}, if3.wrap,
               {28'd0, seq[idx]}, ew);
      end
      if3.ena = 1'b0;

      // ---- default WIDTH=20: 1,2,4,...,0x10000 then 0x20001 ----
      rst20 = 1'b1;
      tick();
      check("w20_reset", {12'd0, if20.out}, if20.wrap, 32'd0, 1'b0);
      rst20 = 1'b0;
      if20.ena = 1'b1;
      for (int n = 1; n <= 18; n++) begin
         logic [31:0] e;
         e = (n <= 17) ? (32'd1 << (n - 1)) : 32'h20001;
         tick();
         check($sformatf("w20_fwd[%0d]", n), {12'd0, if20.out}, if20.wrap, e, 1'b0);
      end
      if20.ena = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
